err_evt_cnt_inst: RTL and testbench

Error event front-end placed directly upstream of the write-1-to-clear error status register. It converts up to 32 level-type error conditions into single-cycle rising-edge pulses on `err_flag_out`, which drives the status register's `err_flag_in`. It also keeps a CPU-visible 32-bit saturating total event counter with a programmable threshold interrupt, on the same CPU register bus.

---
 rtl/err_evt_cnt_inst.sv | 150 +++++++++++++++
 tb/tb_err_evt_cnt_inst.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/err_evt_cnt_inst.sv
// -----------------------------------------------------------------------------
// err_evt_cnt_inst
//
// Error event front-end that feeds the write-1-to-clear error status register.
// Each level-type error source becomes a single-cycle pulse on its rising edge.
// Every pulse is added to a CPU-visible 32-bit saturating event counter. A
// programmable threshold raises a level interrupt while the counter is at or
// above a nonzero threshold.
//
// Parameters
//   VLD_WIDTH   number of error sources (1..32)
//   ADDR_WIDTH  CPU address width
//
// Ports
//   clk           single clock for all logic
//   reset_n       asynchronous active-low reset
//   err_src_in    level error conditions, one bit per source
//   err_flag_out  one-cycle pulse per source rising edge (to err_flag_in)
//   err_int       level interrupt, high while cnt >= thr and thr != 0
//   cpu_addr      CPU address
//   cpu_wr        CPU write strobe, one cycle
//   cpu_data_in   CPU write data
//   cpu_data_out  CPU read data, 0 when no address hits
//   cnt_addr      address of the event counter (read-only, any write clears)
//   thr_addr      address of the threshold register (read/write)
//
// Build option
//   ERR_EVT_SYNC_EN  when defined, a 2-flop synchronizer per bit sits ahead of
//                    edge detection so asynchronous sources can be used. All
//                    source-to-output latencies grow by 2 cycles.
// -----------------------------------------------------------------------------
module err_evt_cnt_inst #(
  parameter int VLD_WIDTH  = 32,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [VLD_WIDTH-1:0]  err_src_in,
  output logic [VLD_WIDTH-1:0]  err_flag_out,
  output logic                  err_int,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_wr,
  input  logic [31:0]           cpu_data_in,
  output logic [31:0]           cpu_data_out,
  input  logic [ADDR_WIDTH-1:0] cnt_addr,
  input  logic [ADDR_WIDTH-1:0] thr_addr
);

  localparam int PW = $clog2(VLD_WIDTH + 1);

  logic [VLD_WIDTH-1:0] src_s;
  logic [VLD_WIDTH-1:0] src_d1;
  logic [VLD_WIDTH-1:0] edge_det;
  logic [PW-1:0]        evt_cnt;
  logic [32:0]          cnt_sum;
  logic [31:0]          cnt_next;
  logic [31:0]          cnt;
  logic [31:0]          thr;
  logic                 cnt_hit;
  logic                 thr_hit;

  // ---------------------------------------------------------------------------
  // Optional input synchronizer
  // ---------------------------------------------------------------------------
`ifdef ERR_EVT_SYNC_EN
  logic [VLD_WIDTH-1:0] sync_q1;
  logic [VLD_WIDTH-1:0] sync_q2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= err_src_in;
      sync_q2 <= sync_q1;
    end
  end

  assign src_s = sync_q2;
`else
  assign src_s = err_src_in;
`endif

  // ---------------------------------------------------------------------------
  // Rising-edge detection. src_d1 clears in reset, so a source already high
  // when reset releases is seen as a fresh edge and pulses once.
  // ---------------------------------------------------------------------------
  assign edge_det = src_s & ~src_d1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_d1       <= '0;
      err_flag_out <= '0;
    end else begin
      src_d1       <= src_s;
      err_flag_out <= edge_det;
    end
  end

  // ---------------------------------------------------------------------------
  // Event counting. Counts the registered pulses, so an event lands in cnt one
  // cycle after its pulse is visible on err_flag_out.
  // ---------------------------------------------------------------------------
  always_comb begin
    evt_cnt = '0;
    for (int i = 0; i < VLD_WIDTH; i++) begin
      evt_cnt = evt_cnt + PW'(err_flag_out[i]);
    end
  end

  // 33-bit sum so the carry out flags saturation instead of wrapping.
  assign cnt_sum  = {1'b0, cnt} + 33'(evt_cnt);
  assign cnt_next = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];

  assign cnt_hit = (cpu_addr == cnt_addr);
  assign thr_hit = (cpu_addr == thr_addr);

  // A clear reloads with this cycle's pulses so events coincident with the
  // clear are not lost. If both addresses alias, one write hits both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      thr     <= '0;
      err_int <= 1'b0;
    end else begin
      if (cpu_wr && cnt_hit) begin
        cnt <= 32'(evt_cnt);
      end else begin
        cnt <= cnt_next;
      end
      if (cpu_wr && thr_hit) begin
        thr <= cpu_data_in;
      end
      err_int <= (thr != 32'd0) && (cnt >= thr);
    end
  end

  // ---------------------------------------------------------------------------
  // Read path. Counter takes priority when the two addresses alias.
  // ---------------------------------------------------------------------------
  always_comb begin
    cpu_data_out = 32'd0;
    if (cnt_hit) begin
      cpu_data_out = cnt;
    end else if (thr_hit) begin
      cpu_data_out = thr;
    end
  end

endmodule

// File: tb/tb_err_evt_cnt_inst.sv
module tb_err_evt_cnt_inst;

`ifdef ERR_EVT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam logic [12:0] CNT_A  = 13'h0010;
  localparam logic [12:0] THR_A  = 13'h0014;
  localparam logic [12:0] MISS_A = 13'h01FF;

  logic        clk;
  logic        reset_n;
  logic [31:0] err_src_in;
  logic [31:0] err_flag_out;
  logic        err_int;
  logic [12:0] cpu_addr;
  logic        cpu_wr;
  logic [31:0] cpu_data_in;
  logic [31:0] cpu_data_out;
  logic [12:0] cnt_addr;
  logic [12:0] thr_addr;

  int checks;
  int errors;

  err_evt_cnt_inst dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .err_src_in   (err_src_in),
    .err_flag_out (err_flag_out),
    .err_int      (err_int),
    .cpu_addr     (cpu_addr),
    .cpu_wr       (cpu_wr),
    .cpu_data_in  (cpu_data_in),
    .cpu_data_out (cpu_data_out),
    .cnt_addr     (cnt_addr),
    .thr_addr     (thr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    checks++;
    if (obs !== exp_val) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [12:0] addr, input logic [31:0] exp_val, input string tag);
    cpu_addr = addr;
    #1;
    chk(tag, cpu_data_out, exp_val);
  endtask

  task automatic wr(input logic [12:0] addr, input logic [31:0] data);
    cpu_addr    = addr;
    cpu_data_in = data;
    cpu_wr      = 1'b1;
    step();
    cpu_wr      = 1'b0;
  endtask

  // Call right after err_src_in rises; ends one edge after the pulse, by which
  // time the counter has absorbed it.
  task automatic expect_pulse(input logic [31:0] mask, input string tag);
    repeat (LAT) step();
    chk({tag, "_pre"}, err_flag_out, 32'h0);
    step();
    chk({tag, "_hi"}, err_flag_out, mask);
    step();
    chk({tag, "_lo"}, err_flag_out, 32'h0);
  endtask

  task automatic evt(input logic [31:0] mask);
    err_src_in = mask;
    repeat (LAT + 2) step();
    err_src_in = 32'h0;
    repeat (LAT + 2) step();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    err_src_in  = 32'h0;
    cpu_addr    = MISS_A;
    cpu_wr      = 1'b0;
    cpu_data_in = 32'h0;
    cnt_addr    = CNT_A;
    thr_addr    = THR_A;

    // reset state
    step();
    step();
    chk("rst_flag", err_flag_out, 32'h0);
    chk("rst_int", {31'h0, err_int}, 32'h0);
    rd(CNT_A, 32'h0, "rst_cnt");
    rd(THR_A, 32'h0, "rst_thr");
    reset_n = 1'b1;
    step();
    step();

    // 1: single-source edges
    err_src_in = 32'h1;
    expect_pulse(32'h1, "t1_p1");
    repeat (8) step();
    chk("t1_hold", err_flag_out, 32'h0);
    rd(CNT_A, 32'd1, "t1_cnt1");
    err_src_in = 32'h0;
    repeat (LAT + 2) step();
    err_src_in = 32'h1;
    expect_pulse(32'h1, "t1_p2");
    rd(CNT_A, 32'd2, "t1_cnt2");
    err_src_in = 32'h0;
    repeat (LAT + 2) step();

    // 2: simultaneous sources
    wr(CNT_A, 32'h1234_5678);
    rd(CNT_A, 32'd0, "t2_clr");
    err_src_in = 32'h8000_0021;
    repeat (LAT) step();
    step();
    chk("t2_hi", err_flag_out, 32'h8000_0021);
    rd(CNT_A, 32'd0, "t2_cnt_before");
    step();
    rd(CNT_A, 32'd3, "t2_cnt_after");
    chk("t2_int", {31'h0, err_int}, 32'h0);
    err_src_in = 32'h0;
    repeat (LAT + 2) step();

    // 3: threshold interrupt
    wr(CNT_A, 32'h0);
    wr(THR_A, 32'd4);
    rd(THR_A, 32'd4, "t3_thr");
    evt(32'h4);
    evt(32'h4);
    evt(32'h4);
    rd(CNT_A, 32'd3, "t3_cnt3");
    chk("t3_int_below", {31'h0, err_int}, 32'h0);
    err_src_in = 32'h4;
    repeat (LAT + 1) step();
    chk("t3_p4_hi", err_flag_out, 32'h4);
    step();
    rd(CNT_A, 32'd4, "t3_cnt4");
    chk("t3_int_lag", {31'h0, err_int}, 32'h0);
    step();
    chk("t3_int_set", {31'h0, err_int}, 32'h1);
    err_src_in = 32'h0;
    repeat (LAT + 2) step();
    chk("t3_int_hold", {31'h0, err_int}, 32'h1);
    wr(THR_A, 32'h0);
    chk("t3_int_w", {31'h0, err_int}, 32'h1);
    step();
    chk("t3_int_off", {31'h0, err_int}, 32'h0);

    // 4: clear/increment collision
    wr(CNT_A, 32'h0);
    evt(32'h0000_007F);
    rd(CNT_A, 32'd7, "t4_cnt7");
    err_src_in = 32'h0000_0300;
    repeat (LAT + 1) step();
    chk("t4_hi", err_flag_out, 32'h0000_0300);
    wr(CNT_A, 32'hDEAD_BEEF);
    rd(CNT_A, 32'd2, "t4_clr_keep");
    err_src_in = 32'h0;
    repeat (LAT + 2) step();
    rd(CNT_A, 32'd2, "t4_stable");

    // 5: saturation via backdoor
    force dut.cnt = 32'hFFFF_FFFE;
    step();
    release dut.cnt;
    rd(CNT_A, 32'hFFFF_FFFE, "t5_preload");
    evt(32'h0000_7000);
    rd(CNT_A, 32'hFFFF_FFFF, "t5_sat");
    evt(32'h0001_0000);
    rd(CNT_A, 32'hFFFF_FFFF, "t5_sat_hold");
    wr(THR_A, 32'hFFFF_FFFF);
    step();
    chk("t5_int_max", {31'h0, err_int}, 32'h1);

    // 6: reset mid-operation, source held through release
    err_src_in = 32'h10;
    repeat (LAT + 1) step();
    chk("t6_inflight", err_flag_out, 32'h10);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_flag", err_flag_out, 32'h0);
    chk("t6_rst_int", {31'h0, err_int}, 32'h0);
    rd(CNT_A, 32'h0, "t6_rst_cnt");
    rd(THR_A, 32'h0, "t6_rst_thr");
    step();
    step();
    reset_n = 1'b1;
    expect_pulse(32'h10, "t6_rel");
    rd(CNT_A, 32'd1, "t6_cnt");
    step();
    chk("t6_once", err_flag_out, 32'h0);
    rd(MISS_A, 32'h0, "t6_miss");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
